// File: rtl/riscv_decode_pkg.sv
// rtl/riscv_decode_pkg.sv - RV32I decode constants, ALU op enum and helpers
// RV32M_DECODE_EN widens the ALU op enum with the M-extension operations.
package riscv_decode_pkg;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

`ifdef RV32M_DECODE_EN
    localparam int ALU_OP_W = 5;
`else
    localparam int ALU_OP_W = 4;
`endif

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
`ifdef RV32M_DECODE_EN
        , ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
`endif
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    // alt selects SUB/SRA; callers only set it where that encoding is legal.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

`ifdef RV32M_DECODE_EN
    function automatic alu_op_e alu_from_mext(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction
`endif

endpackage

// File: rtl/instruction_decode_stage_register_file.sv
// rtl/instruction_decode_stage_register_file.sv - 32x32 register file with x0 rule and write-first bypass
module register_file
    import riscv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // A same-cycle write wins over the stored value so WB needs no extra forwarding path.
    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        if (rs1_addr_i != 5'd0) begin
            rs1_data_o = (we_i && (wa_i == rs1_addr_i)) ? wd_i : regs_q[rs1_addr_i];
        end
        if (rs2_addr_i != 5'd0) begin
            rs2_data_o = (we_i && (wa_i == rs2_addr_i)) ? wd_i : regs_q[rs2_addr_i];
        end
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - RV32I IF/ID latch, decoder and register file (RV32M_DECODE_EN adds M decode)
module instruction_decode_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INSN = riscv_decode_pkg::NOP_INSN
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall_id,
    input  logic                               flush_id,
    input  logic [XLEN-1:0]                    if_pc,
    input  logic [31:0]                        if_instruction,
    input  logic [XLEN-1:0]                    if_pc_plus_4,
    input  logic                               wb_reg_write,
    input  logic [4:0]                         wb_rd,
    input  logic [XLEN-1:0]                    wb_data,
    output logic                               id_valid,
    output logic [XLEN-1:0]                    id_pc,
    output logic [XLEN-1:0]                    id_pc_plus_4,
    output logic [4:0]                         id_rs1,
    output logic [4:0]                         id_rs2,
    output logic [4:0]                         id_rd,
    output logic [XLEN-1:0]                    id_rs1_data,
    output logic [XLEN-1:0]                    id_rs2_data,
    output logic [XLEN-1:0]                    id_imm,
    output logic [2:0]                         id_funct3,
    output logic [riscv_decode_pkg::ALU_OP_W-1:0] id_alu_op,
    output logic                               id_alu_src,
    output logic                               id_mem_read,
    output logic                               id_mem_write,
    output logic                               id_mem_to_reg,
    output logic                               id_reg_write,
    output logic                               id_branch,
    output logic                               id_jump,
    output logic                               id_jalr,
    output logic                               id_illegal
);
    import riscv_decode_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d, pc4_q, pc4_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_id) begin
            instr_d = NOP_INSN;
            valid_d = 1'b0;
        end else if (!stall_id) begin
            pc_d    = if_pc;
            pc4_d   = if_pc_plus_4;
            instr_d = if_instruction;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= NOP_INSN;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    imm_type_e imm_type;
    alu_op_e   alu_op;
    logic      alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic      branch, jump, jalr, illegal;

    always_comb begin
        imm_type   = IMM_NONE;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jalr       = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    alu_op = alu_from_funct3(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    alu_op = alu_from_funct3(funct3, 1'b1);
`ifdef RV32M_DECODE_EN
                end else if (funct7 == F7_MEXT) begin
                    alu_op = alu_from_mext(funct3);
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                imm_type  = IMM_I;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                // Shift immediates borrow funct7 to distinguish SRLI/SRAI.
                if (funct3 == 3'b001) begin
                    alu_op  = ALU_SLL;
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    alu_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end else begin
                    alu_op = alu_from_funct3(funct3, 1'b0);
                end
            end
            OPC_LOAD: begin
                imm_type   = IMM_I;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm_type  = IMM_S;
                alu_src   = 1'b1;
                mem_write = 1'b1;
                illegal   = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                alu_op   = ALU_SUB;
                branch   = 1'b1;
                illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL: begin
                imm_type  = IMM_J;
                jump      = 1'b1;
                reg_write = 1'b1;
            end
            OPC_JALR: begin
                imm_type  = IMM_I;
                jalr      = 1'b1;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                illegal   = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                imm_type  = IMM_U;
                alu_op    = ALU_PASSB;
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type  = IMM_U;
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (imm_type)
            IMM_I:   id_imm = {{20{instr_q[31]}}, instr_q[31:20]};
            IMM_S:   id_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            IMM_B:   id_imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
            IMM_U:   id_imm = {instr_q[31:12], 12'b0};
            IMM_J:   id_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
            default: id_imm = '0;
        endcase
    end

    // Bubbles and illegal encodings must not disturb architectural state downstream.
    logic kill;
    assign kill = !valid_q || illegal;

    assign id_valid      = valid_q;
    assign id_pc         = pc_q;
    assign id_pc_plus_4  = pc4_q;
    assign id_rs1        = instr_q[19:15];
    assign id_rs2        = instr_q[24:20];
    assign id_rd         = instr_q[11:7];
    assign id_funct3     = funct3;
    assign id_alu_op     = kill ? ALU_ADD : alu_op;
    assign id_alu_src    = alu_src    && !kill;
    assign id_mem_read   = mem_read   && !kill;
    assign id_mem_write  = mem_write  && !kill;
    assign id_mem_to_reg = mem_to_reg && !kill;
    assign id_reg_write  = reg_write  && !kill;
    assign id_branch     = branch     && !kill;
    assign id_jump       = jump       && !kill;
    assign id_jalr       = jalr       && !kill;
    assign id_illegal    = valid_q    && illegal;

    register_file #(.XLEN(XLEN)) u_register_file (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr_i (instr_q[19:15]),
        .rs2_addr_i (instr_q[24:20]),
        .rs1_data_o (id_rs1_data),
        .rs2_data_o (id_rs2_data),
        .we_i       (wb_reg_write),
        .wa_i       (wb_rd),
        .wd_i       (wb_data)
    );

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - directed self-checking bench for instruction_decode_stage
module tb_instruction_decode_stage;
    import riscv_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall_id, flush_id, wb_reg_write;
    logic [31:0] if_pc, if_instruction, if_pc_plus_4, wb_data;
    logic [4:0]  wb_rd;
    logic        id_valid, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write;
    logic        id_branch, id_jump, id_jalr, id_illegal;
    logic [31:0] id_pc, id_pc_plus_4, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [ALU_OP_W-1:0] id_alu_op;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_decode_stage dut (
        .clk(clk), .rst(rst), .stall_id(stall_id), .flush_id(flush_id),
        .if_pc(if_pc), .if_instruction(if_instruction), .if_pc_plus_4(if_pc_plus_4),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_funct3(id_funct3), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_reg_write(id_reg_write), .id_branch(id_branch), .id_jump(id_jump),
        .id_jalr(id_jalr), .id_illegal(id_illegal)
    );

    task step();
        @(posedge clk);
        #1;
    endtask

    task load(input logic [31:0] insn, input logic [31:0] pc);
        if_instruction = insn;
        if_pc          = pc;
        if_pc_plus_4   = pc + 32'd4;
        step();
    endtask

    task test_reset();
        logic [4:0] r;
        rst = 1'b0; stall_id = 1'b0; flush_id = 1'b0; wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        if_instruction = 32'h00500093; if_pc = 32'h40; if_pc_plus_4 = 32'h44;
        repeat (2) step();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if (id_reg_write !== 1'b0) begin failures++; $display("FAIL reset_reg_write got=%b exp=0", id_reg_write); end
        checks++; if (id_alu_src !== 1'b0) begin failures++; $display("FAIL reset_alu_src got=%b exp=0", id_alu_src); end
        checks++; if (id_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", id_illegal); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
        checks++; if (id_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", id_rd); end
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r = i[4:0];
            load({7'b0, r, r, 3'b000, 5'd0, 7'b0110011}, 32'h0);
            checks++;
            if (id_rs1_data !== 32'h0 || id_rs2_data !== 32'h0 || id_rs1 !== r)
                begin failures++; $display("FAIL reset_regfile x%0d got rs1=%0d d1=%h d2=%h exp zero data", i, id_rs1, id_rs1_data, id_rs2_data); end
        end
    endtask

    task test_load();
        load(32'h00500093, 32'h100);
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL load_valid got=%b exp=1", id_valid); end
        checks++; if (id_rd !== 5'd1) begin failures++; $display("FAIL load_rd got=%0d exp=1", id_rd); end
        checks++; if (id_imm !== 32'h5) begin failures++; $display("FAIL load_imm got=%h exp=5", id_imm); end
        checks++; if (id_alu_src !== 1'b1 || id_reg_write !== 1'b1) begin failures++; $display("FAIL load_ctrl got src=%b rw=%b exp 1 1", id_alu_src, id_reg_write); end
        checks++; if (id_alu_op !== ALU_ADD) begin failures++; $display("FAIL load_alu_op got=%0d exp=%0d", id_alu_op, ALU_ADD); end
        checks++; if (id_pc !== 32'h100 || id_pc_plus_4 !== 32'h104) begin failures++; $display("FAIL load_pc got=%h/%h exp 100/104", id_pc, id_pc_plus_4); end
        checks++; if (id_mem_read !== 1'b0 || id_illegal !== 1'b0) begin failures++; $display("FAIL load_misc got mr=%b ill=%b exp 0 0", id_mem_read, id_illegal); end
    endtask

    task test_stall_flush();
        load(32'h00208133, 32'h200);
        checks++; if (id_rs1 !== 5'd1 || id_rs2 !== 5'd2 || id_rd !== 5'd2) begin failures++; $display("FAIL add_fields got %0d %0d %0d exp 1 2 2", id_rs1, id_rs2, id_rd); end
        checks++; if (id_reg_write !== 1'b1 || id_alu_src !== 1'b0) begin failures++; $display("FAIL add_ctrl got rw=%b src=%b exp 1 0", id_reg_write, id_alu_src); end
        stall_id = 1'b1;
        load(32'h00500093, 32'h300);
        checks++; if (id_pc !== 32'h200 || id_rd !== 5'd2 || id_alu_src !== 1'b0 || id_valid !== 1'b1)
            begin failures++; $display("FAIL stall_hold got pc=%h rd=%0d src=%b v=%b exp 200 2 0 1", id_pc, id_rd, id_alu_src, id_valid); end
        flush_id = 1'b1;
        step();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", id_valid); end
        checks++; if (id_reg_write !== 1'b0 || id_alu_src !== 1'b0 || id_rd !== 5'd0) begin failures++; $display("FAIL flush_ctrl got rw=%b src=%b rd=%0d exp 0 0 0", id_reg_write, id_alu_src, id_rd); end
        flush_id = 1'b0; stall_id = 1'b0;
    endtask

    task test_bypass();
        load(32'h000182B3, 32'h400);
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        #1;
        checks++; if (id_rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rs1 got=%h exp=deadbeef", id_rs1_data); end
        checks++; if (id_rs2_data !== 32'h0) begin failures++; $display("FAIL bypass_rs2_x0 got=%h exp=0", id_rs2_data); end
        step();
        wb_reg_write = 1'b0;
        #1;
        checks++; if (id_rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL stored_x3 got=%h exp=deadbeef", id_rs1_data); end
        load(32'h000002B3, 32'h404);
        wb_reg_write = 1'b1; wb_rd = 5'd0;
        #1;
        checks++; if (id_rs1_data !== 32'h0) begin failures++; $display("FAIL bypass_x0 got=%h exp=0", id_rs1_data); end
        step();
        wb_reg_write = 1'b0;
        #1;
        checks++; if (id_rs1_data !== 32'h0) begin failures++; $display("FAIL write_x0 got=%h exp=0", id_rs1_data); end
        load(32'h003002B3, 32'h408);
        checks++; if (id_rs2_data !== 32'hDEADBEEF) begin failures++; $display("FAIL read_rs2_x3 got=%h exp=deadbeef", id_rs2_data); end
    endtask

    task test_immediates();
        load(32'hFE000EE3, 32'h500);
        checks++; if (id_imm !== 32'hFFFFFFFC || id_branch !== 1'b1) begin failures++; $display("FAIL beq got imm=%h br=%b exp fffffffc 1", id_imm, id_branch); end
        checks++; if (id_alu_op !== ALU_SUB || id_reg_write !== 1'b0) begin failures++; $display("FAIL beq_ctrl got op=%0d rw=%b exp %0d 0", id_alu_op, id_reg_write, ALU_SUB); end
        load(32'h123450B7, 32'h504);
        checks++; if (id_imm !== 32'h12345000) begin failures++; $display("FAIL lui_imm got=%h exp=12345000", id_imm); end
        checks++; if (id_alu_op !== ALU_PASSB || id_alu_src !== 1'b1 || id_reg_write !== 1'b1) begin failures++; $display("FAIL lui_ctrl got op=%0d src=%b rw=%b", id_alu_op, id_alu_src, id_reg_write); end
        load(32'hFE20AC23, 32'h508);
        checks++; if (id_imm !== 32'hFFFFFFF8 || id_mem_write !== 1'b1 || id_reg_write !== 1'b0) begin failures++; $display("FAIL sw got imm=%h mw=%b rw=%b exp fffffff8 1 0", id_imm, id_mem_write, id_reg_write); end
        load(32'h008000EF, 32'h50C);
        checks++; if (id_imm !== 32'h8 || id_jump !== 1'b1 || id_reg_write !== 1'b1) begin failures++; $display("FAIL jal got imm=%h j=%b rw=%b exp 8 1 1", id_imm, id_jump, id_reg_write); end
        load(32'hFFF12283, 32'h510);
        checks++; if (id_imm !== 32'hFFFFFFFF || id_mem_read !== 1'b1 || id_mem_to_reg !== 1'b1 || id_funct3 !== 3'b010) begin failures++; $display("FAIL lw got imm=%h mr=%b m2r=%b f3=%b", id_imm, id_mem_read, id_mem_to_reg, id_funct3); end
        load(32'hFFFFF297, 32'h514);
        checks++; if (id_imm !== 32'hFFFFF000 || id_alu_op !== ALU_ADD || id_alu_src !== 1'b1) begin failures++; $display("FAIL auipc got imm=%h op=%0d src=%b exp fffff000 0 1", id_imm, id_alu_op, id_alu_src); end
        load(32'h00008067, 32'h518);
        checks++; if (id_jalr !== 1'b1 || id_alu_src !== 1'b1 || id_imm !== 32'h0) begin failures++; $display("FAIL jalr got jalr=%b src=%b imm=%h exp 1 1 0", id_jalr, id_alu_src, id_imm); end
    endtask

    task test_illegal();
        load(32'h0000007F, 32'h600);
        checks++; if (id_illegal !== 1'b1 || id_reg_write !== 1'b0) begin failures++; $display("FAIL bad_opcode got ill=%b rw=%b exp 1 0", id_illegal, id_reg_write); end
        load(32'h40209133, 32'h604);
        checks++; if (id_illegal !== 1'b1 || id_reg_write !== 1'b0) begin failures++; $display("FAIL bad_funct7 got ill=%b rw=%b exp 1 0", id_illegal, id_reg_write); end
        load(32'h40208133, 32'h608);
        checks++; if (id_illegal !== 1'b0 || id_alu_op !== ALU_SUB) begin failures++; $display("FAIL sub got ill=%b op=%0d exp 0 %0d", id_illegal, id_alu_op, ALU_SUB); end
        load(32'h4030D093, 32'h60C);
        checks++; if (id_illegal !== 1'b0 || id_alu_op !== ALU_SRA || id_imm[4:0] !== 5'd3) begin failures++; $display("FAIL srai got ill=%b op=%0d sh=%0d", id_illegal, id_alu_op, id_imm[4:0]); end
        load(32'h02208133, 32'h610);
`ifdef RV32M_DECODE_EN
        checks++; if (id_illegal !== 1'b0 || id_alu_op !== ALU_MUL || id_reg_write !== 1'b1) begin failures++; $display("FAIL mul got ill=%b op=%0d rw=%b exp 0 %0d 1", id_illegal, id_alu_op, id_reg_write, ALU_MUL); end
`else
        checks++; if (id_illegal !== 1'b1 || id_reg_write !== 1'b0) begin failures++; $display("FAIL mul got ill=%b rw=%b exp 1 0", id_illegal, id_reg_write); end
`endif
        load(32'h0000007F, 32'h614);
        flush_id = 1'b1;
        step();
        flush_id = 1'b0;
        checks++; if (id_illegal !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL bubble_illegal got ill=%b v=%b exp 0 0", id_illegal, id_valid); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall_flush();
        test_bypass();
        test_immediates();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
- RV32I decode stage directly downstream of instruction fetch; owns the IF/ID pipeline latch and the architectural register file.
- Captures fetch outputs (pc, instruction, pc+4) each cycle subject to stall/flush.
- Decodes the latched instruction into ID/EX control, immediates and register operands.
- Accepts the write-back port from the WB stage.

Parameters:
- XLEN, 32, datapath width.
- NOP_INSN, 32'h00000013, bubble instruction (addi x0,x0,0) loaded on reset/flush.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- stall_id  in  1  hold IF/ID latch (from hazard unit)
- flush_id  in  1  squash IF/ID latch (branch/jump taken)
- if_pc  in  32  fetch PC
- if_instruction  in  32  fetched instruction
- if_pc_plus_4  in  32  fetch PC+4
- wb_reg_write  in  1  write-back enable
- wb_rd  in  5  write-back register
- wb_data  in  32  write-back data
- id_valid  out  1  latched instruction is real (not a bubble)
- id_pc, id_pc_plus_4  out  32  latched PC values
- id_rs1, id_rs2, id_rd  out  5  register fields (feed hazard/forwarding)
- id_rs1_data, id_rs2_data  out  32  register operands
- id_imm  out  32  sign-extended immediate
- id_funct3  out  3  funct3 field
- id_alu_op  out  4  ALU operation (package enum)
- id_alu_src  out  1  1 = immediate operand B
- id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write  out  1  memory/WB control
- id_branch, id_jump, id_jalr  out  1  control-flow class
- id_illegal  out  1  valid instruction with unsupported encoding

Behaviour:
- Latch reset (rst==0 at posedge): pc=0, pc_plus_4=0, instruction=NOP_INSN, valid=0.
- Latch priority at posedge: reset > flush_id > stall_id > load.
  - flush: instruction=NOP_INSN, valid=0.
  - stall: hold all fields.
  - load: capture if_* and set valid=1.
- flush_id and stall_id both high: flush wins.
- Register file: 32x32.
  - rst==0 clears all entries.
  - Write at posedge when wb_reg_write && wb_rd!=0; x0 always reads 0.
  - Reads are combinational from the latched rs1/rs2.
  - Write-first bypass: if wb_reg_write && wb_rd==rs && rs!=0, the read returns wb_data in the same cycle.
- Decode is combinational from the latch; there is zero latency after latch capture.
- Immediate formats (all sign-extended from instr[31]):
  - I: opcodes 0010011/0000011/1100111.
  - S: 0100011.
  - B: 1100011, bit0=0.
  - U: 0110111/0010111, low 12 bits=0.
  - J: 1101111, bit0=0.
  - All other opcodes: imm=0.
- Control mapping:
  - R-type: reg_write; alu_op from funct3/funct7[5].
  - I-ALU: alu_src, reg_write; SRAI uses funct7[5].
  - LOAD: mem_read, mem_to_reg, reg_write, alu_src, alu_op=ADD.
  - STORE: mem_write, alu_src, alu_op=ADD.
  - BRANCH: branch, alu_op=SUB.
  - JAL: jump, reg_write.
  - JALR: jalr, reg_write, alu_src.
  - LUI: alu_op=PASSB, alu_src, reg_write.
  - AUIPC: alu_op=ADD, alu_src, reg_write (EX selects PC as operand A).
- Bubble: valid==0 forces all control outputs and id_illegal to 0. id_rs*/id_rd still reflect NOP fields (0).
- Illegal handling:
  - Unknown opcode, or undefined funct3/funct7 combination: id_illegal=1 when valid.
  - All write/memory/branch controls are forced to 0 for an illegal instruction.
- Writes with rd==0 still decode reg_write=1; the register file ignores them.

Optional Feature:
- Macro: RV32M_DECODE_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes to alu_op MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, with reg_write=1. This requires alu_op to be widened to 5 bits; the package defines the width.
- Undefined: those encodings set id_illegal=1 and all controls to 0.

Decomposition:
- Package riscv_decode_pkg holds:
  - opcode constants;
  - alu_op enum and its width, conditional on RV32M_DECODE_EN;
  - NOP_INSN;
  - immediate-type enum.
- One sub-module: register_file (storage, x0 rule, write-first bypass).
- Latch and decode logic stay in the top module.

Test Plan:
- Reset: rst=0 for 2 cycles → id_valid=0, all controls=0, rs1_data=0 for every register read.
- Load: if_instruction=32'h00500093 (addi x1,x0,5), no stall → next cycle id_valid=1, id_rd=1, id_imm=5, alu_src=1, reg_write=1, alu_op=ADD.
- Stall then flush:
  - Latch 32'h00208133 (add x2,x1,x2), then stall_id=1 with a new if_* → outputs unchanged.
  - Then flush_id=1 together with stall_id=1 → id_valid=0, controls 0.
- Bypass: wb_reg_write=1, wb_rd=3, wb_data=32'hDEADBEEF in the same cycle as latched rs1=3 → id_rs1_data=DEADBEEF. With wb_rd=0 → x0 reads 0.
- Immediates:
  - 32'hFE000EE3 (beq, offset −4) → id_imm=32'hFFFFFFFC, branch=1.
  - 32'h123450B7 (lui) → id_imm=32'h12345000.
- Illegal:
  - opcode 1111111 → id_illegal=1, reg_write=0.
  - 32'h02208133 (mul) → illegal without RV32M_DECODE_EN; alu_op=MUL, reg_write=1 with it.
